rom_ddr_loader: RTL and testbench

Streams the HPS ROM download (ioctl byte interface) into DDRAM as 64-bit single-beat writes so large graphics and sound ROMs can live off-chip instead of in BRAM. Sits between `hps_io` and the DDRAM Avalon port in `emu`, alongside the existing BRAM load path into `AthenaCore`. It packs bytes into 64-bit words, throttles the HPS with `ioctl_wait` while DDRAM is busy, and flushes any partial word when the download ends.

---
 rtl/rom_ddr_loader_if.sv | 27 ++
 rtl/rom_ddr_loader.sv | 141 ++++++++++++++
 tb/tb_rom_ddr_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_ddr_loader_if.sv
// HPS ioctl download bus and DDRAM Avalon write port bundled for the ROM loader.
// The slave modport is the loader's view; master is the HPS/DDRAM side.
interface rom_ddr_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        DDRAM_BUSY;
  logic [7:0]  DDRAM_BURSTCNT;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic        DDRAM_WE;
  logic        DDRAM_RD;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, DDRAM_BUSY,
    output ioctl_wait, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, DDRAM_BUSY,
    input  ioctl_wait, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD
  );
endinterface

// File: rtl/rom_ddr_loader.sv
// Packs the HPS ROM byte stream into 64-bit single-beat DDRAM writes, stalling
// the HPS while a write is outstanding and flushing the partial word at the end.
module rom_ddr_loader #(
  parameter logic [28:0] BASE_ADDR = 29'h0,
  parameter logic [7:0]  INDEX     = 8'd0
) (
  input  logic               clk_sys,
  input  logic               reset,
  rom_ddr_loader_if.slave    bus,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, FINISH} state_t;

  state_t      state_q, state_d;
  logic [63:0] pk_data_q, pk_data_d;
  logic [7:0]  pk_be_q, pk_be_d;
  logic [28:0] pk_addr_q, pk_addr_d;
  logic        pk_valid_q, pk_valid_d;
  logic        wr_valid_q, wr_valid_d;
  logic [28:0] ddr_addr_q, ddr_addr_d;
  logic [63:0] ddr_din_q, ddr_din_d;
  logic [7:0]  ddr_be_q, ddr_be_d;

  logic        sel_idx, cap, same_word;
  logic [28:0] word;
  logic [2:0]  lane;
  logic [63:0] mg_data;
  logic [7:0]  mg_be;

  // A strobe arriving while a write is still pending breaks the HPS contract and is dropped
  assign sel_idx   = (bus.ioctl_index == INDEX);
  assign cap       = bus.ioctl_wr && bus.ioctl_download && sel_idx && !wr_valid_q;
  assign word      = BASE_ADDR + {7'd0, bus.ioctl_addr[24:3]};
  assign lane      = bus.ioctl_addr[2:0];
  assign same_word = pk_valid_q && (word == pk_addr_q);

  always_comb begin
    mg_data = same_word ? pk_data_q : '0;
    mg_be   = same_word ? pk_be_q   : '0;
    mg_data[{lane, 3'b000} +: 8] = bus.ioctl_dout;
    mg_be[lane] = 1'b1;
  end

  // Pack -> write stage transfer
  always_comb begin
    pk_data_d  = pk_data_q;
    pk_be_d    = pk_be_q;
    pk_addr_d  = pk_addr_q;
    pk_valid_d = pk_valid_q;
    wr_valid_d = wr_valid_q;
    ddr_addr_d = ddr_addr_q;
    ddr_din_d  = ddr_din_q;
    ddr_be_d   = ddr_be_q;
    if (wr_valid_q && !bus.DDRAM_BUSY)
      wr_valid_d = 1'b0;
    if (cap) begin
      if (pk_valid_q && !same_word) begin
        wr_valid_d = 1'b1;
        ddr_addr_d = pk_addr_q;
        ddr_din_d  = pk_data_q;
        ddr_be_d   = pk_be_q;
        pk_data_d  = mg_data;
        pk_be_d    = mg_be;
        pk_addr_d  = word;
        pk_valid_d = 1'b1;
      end else if (lane == 3'd7) begin
        wr_valid_d = 1'b1;
        ddr_addr_d = word;
        ddr_din_d  = mg_data;
        ddr_be_d   = mg_be;
        pk_data_d  = '0;
        pk_be_d    = '0;
        pk_valid_d = 1'b0;
      end else begin
        pk_data_d  = mg_data;
        pk_be_d    = mg_be;
        pk_addr_d  = word;
        pk_valid_d = 1'b1;
      end
    end else if (state_q == FLUSH && pk_valid_q && !wr_valid_q) begin
      wr_valid_d = 1'b1;
      ddr_addr_d = pk_addr_q;
      ddr_din_d  = pk_data_q;
      ddr_be_d   = pk_be_q;
      pk_data_d  = '0;
      pk_be_d    = '0;
      pk_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pk_data_q  <= '0;
      pk_be_q    <= '0;
      pk_addr_q  <= '0;
      pk_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      ddr_addr_q <= '0;
      ddr_din_q  <= '0;
      ddr_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      pk_data_q  <= pk_data_d;
      pk_be_q    <= pk_be_d;
      pk_addr_q  <= pk_addr_d;
      pk_valid_q <= pk_valid_d;
      wr_valid_q <= wr_valid_d;
      ddr_addr_q <= ddr_addr_d;
      ddr_din_q  <= ddr_din_d;
      ddr_be_q   <= ddr_be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap) state_d = LOAD;
      LOAD:    if (!bus.ioctl_download || !sel_idx) state_d = FLUSH;
      FLUSH:   if (!pk_valid_q && !wr_valid_q) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == FINISH);
  end

  assign bus.ioctl_wait     = wr_valid_q;
  assign bus.DDRAM_WE       = wr_valid_q;
  assign bus.DDRAM_ADDR     = ddr_addr_q;
  assign bus.DDRAM_DIN      = ddr_din_q;
  assign bus.DDRAM_BE       = ddr_be_q;
  assign bus.DDRAM_BURSTCNT = 8'd1;
  assign bus.DDRAM_RD       = 1'b0;

endmodule

// File: tb/tb_rom_ddr_loader.sv
// Directed bench for rom_ddr_loader: drives ioctl downloads and checks the
// DDRAM writes, stall behaviour and busy/done handshake against hand-computed values.
module tb_rom_ddr_loader;
  localparam logic [28:0] BASE = 29'h0001000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic busy, done;

  rom_ddr_loader_if bus();

  rom_ddr_loader #(.BASE_ADDR(BASE), .INDEX(8'd0)) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor: records accepted writes and running counters
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  logic [28:0] wq_addr[$];
  logic [63:0] wq_din[$];
  logic [7:0]  wq_be[$];
  int we_cyc = 0, wait_cyc = 0, busy_cyc = 0, done_cnt = 0;
  int unstable = 0, viol = 0, last_acc = 0, done_at = 0;
  logic        prev_we = 1'b0;
  logic [28:0] prev_addr = '0;
  logic [63:0] prev_din = '0;
  logic [7:0]  prev_be = '0;

  always @(negedge clk_sys) begin
    if (bus.DDRAM_WE === 1'b1) begin
      we_cyc++;
      if (prev_we && (bus.DDRAM_ADDR !== prev_addr || bus.DDRAM_DIN !== prev_din ||
                      bus.DDRAM_BE !== prev_be))
        unstable++;
    end
    if (bus.ioctl_wait === 1'b1) wait_cyc++;
    if (busy === 1'b1) busy_cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_at = cyc;
    end
    if (bus.ioctl_wr === 1'b1 && bus.ioctl_wait === 1'b1) viol++;
    if (bus.DDRAM_WE === 1'b1 && bus.DDRAM_BUSY === 1'b0) begin
      wq_addr.push_back(bus.DDRAM_ADDR);
      wq_din.push_back(bus.DDRAM_DIN);
      wq_be.push_back(bus.DDRAM_BE);
      last_acc = cyc;
    end
    prev_we   = (bus.DDRAM_WE === 1'b1);
    prev_addr = bus.DDRAM_ADDR;
    prev_din  = bus.DDRAM_DIN;
    prev_be   = bus.DDRAM_BE;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int t = 0;
    while (bus.ioctl_wait && t < 50) begin
      @(posedge clk_sys);
      #1;
      t++;
    end
    if (t >= 50) check("wait_bound", 64'(t), 64'd0);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr   = 1'b0;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && t < 100) begin
      @(posedge clk_sys);
      t++;
    end
    #1;
    check(tag, 64'(done_cnt != d0), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int w0, we0, wt0, b0, d0, u0, v0;

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    bus.DDRAM_BUSY     = 1'b0;
    idle(3);

    check("rst_we",    64'(bus.DDRAM_WE),       64'd0);
    check("rst_wait",  64'(bus.ioctl_wait),     64'd0);
    check("rst_busy",  64'(busy),               64'd0);
    check("rst_done",  64'(done),               64'd0);
    check("rst_addr",  64'(bus.DDRAM_ADDR),     64'd0);
    check("rst_din",   bus.DDRAM_DIN,           64'd0);
    check("rst_be",    64'(bus.DDRAM_BE),       64'd0);
    check("burstcnt",  64'(bus.DDRAM_BURSTCNT), 64'd1);
    check("rd",        64'(bus.DDRAM_RD),       64'd0);
    #2 reset = 1'b0;
    idle(2);

    // Contiguous word
    w0 = wq_addr.size(); we0 = we_cyc; d0 = done_cnt;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'((i + 1) * 17));
    idle(3);
    check("cw_nwr",  64'(wq_addr.size() - w0), 64'd1);
    check("cw_addr", 64'(wq_addr[w0]),         64'(BASE));
    check("cw_din",  wq_din[w0],               64'h8877665544332211);
    check("cw_be",   64'(wq_be[w0]),           64'hFF);
    check("cw_we_len", 64'(we_cyc - we0),      64'd1);
    check("cw_busy", 64'(busy),                64'd1);
    bus.ioctl_download = 1'b0;
    wait_done("cw_done_seen");
    idle(3);
    check("cw_done_cnt", 64'(done_cnt - d0),   64'd1);
    check("cw_busy_end", 64'(busy),            64'd0);

    // Partial tail
    w0 = wq_addr.size(); d0 = done_cnt;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 10; i++) send_byte(25'(i), 8'(i + 1));
    idle(2);
    bus.ioctl_download = 1'b0;
    wait_done("pt_done_seen");
    idle(3);
    check("pt_nwr",   64'(wq_addr.size() - w0), 64'd2);
    check("pt_addr0", 64'(wq_addr[w0]),         64'(BASE));
    check("pt_din0",  wq_din[w0],               64'h0807060504030201);
    check("pt_be0",   64'(wq_be[w0]),           64'hFF);
    check("pt_addr1", 64'(wq_addr[w0+1]),       64'(BASE + 29'd1));
    check("pt_din1",  64'(wq_din[w0+1][15:0]),  64'h0A09);
    check("pt_be1",   64'(wq_be[w0+1]),         64'h03);
    check("pt_done_cnt", 64'(done_cnt - d0),    64'd1);
    check("pt_done_lat", 64'(done_at - last_acc), 64'd2);
    check("pt_busy",  64'(busy),                64'd0);

    // Non-contiguous bytes
    w0 = wq_addr.size();
    bus.ioctl_download = 1'b1;
    send_byte(25'h3, 8'hAA);
    send_byte(25'h100, 8'hBB);
    idle(2);
    check("nc_nwr_mid", 64'(wq_addr.size() - w0), 64'd1);
    check("nc_addr0",   64'(wq_addr[w0]),         64'(BASE));
    check("nc_be0",     64'(wq_be[w0]),           64'h08);
    check("nc_lane3",   64'(wq_din[w0][31:24]),   64'hAA);
    bus.ioctl_download = 1'b0;
    wait_done("nc_done_seen");
    idle(2);
    check("nc_nwr",     64'(wq_addr.size() - w0), 64'd2);
    check("nc_addr1",   64'(wq_addr[w0+1]),       64'(BASE + 29'h20));
    check("nc_be1",     64'(wq_be[w0+1]),         64'h01);
    check("nc_lane0",   64'(wq_din[w0+1][7:0]),   64'hBB);

    // Backpressure: BUSY high for 5 cycles of the write
    w0 = wq_addr.size();
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 7; i++) send_byte(25'(8'h40 + i), 8'(8'h30 + i));
    we0 = we_cyc; wt0 = wait_cyc; u0 = unstable; v0 = viol;
    bus.DDRAM_BUSY = 1'b1;
    bus.ioctl_addr = 25'h47;
    bus.ioctl_dout = 8'h37;
    bus.ioctl_wr   = 1'b1;
    @(posedge clk_sys);
    #1;
    bus.ioctl_wr   = 1'b0;
    repeat (5) @(posedge clk_sys);
    #1;
    bus.DDRAM_BUSY = 1'b0;
    send_byte(25'h48, 8'h99);
    idle(3);
    check("bp_we_len",   64'(we_cyc - we0),        64'd6);
    check("bp_wait_len", 64'(wait_cyc - wt0),      64'd6);
    check("bp_stable",   64'(unstable - u0),       64'd0);
    check("bp_no_viol",  64'(viol - v0),           64'd0);
    check("bp_nwr_mid",  64'(wq_addr.size() - w0), 64'd1);
    check("bp_addr0",    64'(wq_addr[w0]),         64'(BASE + 29'd8));
    check("bp_din0",     wq_din[w0],               64'h3736353433323130);
    check("bp_be0",      64'(wq_be[w0]),           64'hFF);
    bus.ioctl_download = 1'b0;
    wait_done("bp_done_seen");
    idle(2);
    check("bp_addr1",    64'(wq_addr[w0+1]),       64'(BASE + 29'd9));
    check("bp_be1",      64'(wq_be[w0+1]),         64'h01);
    check("bp_lane0",    64'(wq_din[w0+1][7:0]),   64'h99);

    // Index filter
    w0 = wq_addr.size(); we0 = we_cyc; b0 = busy_cyc; d0 = done_cnt;
    bus.ioctl_index    = 8'd1;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'h50 + i));
    bus.ioctl_download = 1'b0;
    idle(20);
    check("if_nwr",  64'(wq_addr.size() - w0), 64'd0);
    check("if_we",   64'(we_cyc - we0),        64'd0);
    check("if_busy", 64'(busy_cyc - b0),       64'd0);
    check("if_done", 64'(done_cnt - d0),       64'd0);
    bus.ioctl_index = 8'd0;

    // Reset while a write is stalled
    w0 = wq_addr.size();
    bus.ioctl_download = 1'b1;
    bus.DDRAM_BUSY     = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(8'hA0 + i));
    check("rm_we_pre", 64'(bus.DDRAM_WE), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rm_we",   64'(bus.DDRAM_WE),   64'd0);
    check("rm_wait", 64'(bus.ioctl_wait), 64'd0);
    check("rm_busy", 64'(busy),           64'd0);
    bus.ioctl_download = 1'b0;
    idle(2);
    reset = 1'b0;
    bus.DDRAM_BUSY = 1'b0;
    idle(2);
    check("rm_nwr", 64'(wq_addr.size() - w0), 64'd0);

    w0 = wq_addr.size(); we0 = we_cyc; d0 = done_cnt;
    bus.ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(25'(i), 8'((i + 1) * 17));
    idle(3);
    check("rf_nwr",  64'(wq_addr.size() - w0), 64'd1);
    check("rf_addr", 64'(wq_addr[w0]),         64'(BASE));
    check("rf_din",  wq_din[w0],               64'h8877665544332211);
    check("rf_be",   64'(wq_be[w0]),           64'hFF);
    check("rf_we_len", 64'(we_cyc - we0),      64'd1);
    bus.ioctl_download = 1'b0;
    wait_done("rf_done_seen");
    idle(3);
    check("rf_done_cnt", 64'(done_cnt - d0),   64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
